// File: rtl/alu_exec_pkg.sv
// Shared definitions for the iterative ALU execution block: default data
// width, opcode encoding and controller state encoding.
package alu_exec_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle arithmetic/logic unit: y = a op b for ADD/SUB/AND/OR/XOR.
// c is the carry out for ADD, the borrow (a < b unsigned) for SUB, and 0
// for the logic operations. Iterative opcodes produce zero here.
module alu_comb
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output logic             c
);

  logic [WIDTH:0] wide;

  // Result and carry/borrow selection by opcode.
  always_comb begin
    wide = '0;
    y    = '0;
    c    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        y    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
      end
      OP_SUB: begin
        // The extra MSB of the widened difference is set exactly when a < b.
        wide = {1'b0, a} - {1'b0, b};
        y    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Two-address ALU execution unit (result = d op s) with a register-file
// write-back interface. Logic ops and ADD/SUB finish in one cycle; MUL is a
// shift-add over WIDTH cycles; SHL/SHR shift one bit per cycle, s[2:0] times.
//
// Handshake: start is sampled on a rising edge only while the controller is
// in IDLE or DONE (busy low); operands, opcode and dr are captured on that
// edge. The result appears as a one-cycle done/we pulse; i, dr_out, cf and zf
// are registered, change only on entry to DONE, and hold until the next DONE.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [1:0]       dr,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic             we,
  output logic [WIDTH-1:0] i,
  output logic [1:0]       dr_out,
  output logic             cf,
  output logic             zf,
  output state_e           dbg_state_o
);

  // Counter must reach both WIDTH-1 (multiply) and 7 (largest shift).
  localparam int CNT_W = ($clog2(WIDTH + 1) > 3) ? $clog2(WIDTH + 1) : 3;

  state_e               state_q,  state_d;
  op_e                  op_q,     op_d;
  logic [1:0]           dr_q,     dr_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     sh_q,     sh_d;
  logic [2:0]           shn_q,    shn_d;
  logic [WIDTH-1:0]     i_q,      i_d;
  logic [1:0]           dr_out_q, dr_out_d;
  logic                 cf_q,     cf_d;
  logic                 zf_q,     zf_d;

  op_e                  op_in;
  logic [WIDTH-1:0]     alu_y;
  logic                 alu_c;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     sh_step;
  logic                 sh_bit;
  logic [CNT_W-1:0]     cnt_inc;

  assign op_in = op_e'(op);

  // Single-cycle ops are evaluated straight from the live inputs in the
  // acceptance cycle, so their result is registered on the accepting edge.
  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .a  (d),
    .b  (s),
    .op (op_in),
    .y  (alu_y),
    .c  (alu_c)
  );

  // Next-state, datapath step and result capture.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dr_d     = dr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sh_d     = sh_q;
    shn_d    = shn_q;
    i_d      = i_q;
    dr_out_d = dr_out_q;
    cf_d     = cf_q;
    zf_d     = zf_q;

    cnt_inc  = cnt_q + CNT_W'(1);
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    if (op_q == OP_SHR) begin
      sh_step = sh_q >> 1;
      sh_bit  = sh_q[0];
    end else begin
      sh_step = sh_q << 1;
      sh_bit  = sh_q[WIDTH-1];
    end

    case (state_q)
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (op_q == OP_MUL) begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            i_d      = acc_step[WIDTH-1:0];
            cf_d     = |acc_step[2*WIDTH-1:WIDTH];
            zf_d     = (acc_step[WIDTH-1:0] == '0);
            dr_out_d = dr_q;
            state_d  = ST_DONE;
          end
        end else begin
          sh_d = sh_step;
          if (cnt_inc == CNT_W'(shn_q)) begin
            i_d      = sh_step;
            cf_d     = sh_bit;
            zf_d     = (sh_step == '0);
            dr_out_d = dr_q;
            state_d  = ST_DONE;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE falls back to IDLE.
        state_d = ST_IDLE;
        if (start) begin
          op_d  = op_in;
          dr_d  = dr;
          cnt_d = '0;
          case (op_in)
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, d};
              mplier_d = s;
              state_d  = ST_RUN;
            end
            OP_SHL, OP_SHR: begin
              sh_d  = d;
              shn_d = s[2:0];
              if (s[2:0] == 3'd0) begin
                i_d      = d;
                cf_d     = 1'b0;
                zf_d     = (d == '0);
                dr_out_d = dr;
                state_d  = ST_DONE;
              end else begin
                state_d  = ST_RUN;
              end
            end
            default: begin
              i_d      = alu_y;
              cf_d     = alu_c;
              zf_d     = (alu_y == '0);
              dr_out_d = dr;
              state_d  = ST_DONE;
            end
          endcase
        end
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      dr_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sh_q     <= '0;
      shn_q    <= '0;
      i_q      <= '0;
      dr_out_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dr_q     <= dr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sh_q     <= sh_d;
      shn_q    <= shn_d;
      i_q      <= i_d;
      dr_out_q <= dr_out_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign we          = (state_q == ST_DONE);
  assign i           = i_q;
  assign dr_out      = dr_out_q;
  assign cf          = cf_q;
  assign zf          = zf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_exec.sv
// Testbench for alu_exec: directed cases for the documented vectors plus
// randomized operations, checked by a scoreboard against an arithmetic
// reference model.
module tb_alu_exec;

  localparam int W = 8;

  localparam logic [2:0] T_ADD = 3'd0;
  localparam logic [2:0] T_SUB = 3'd1;
  localparam logic [2:0] T_AND = 3'd2;
  localparam logic [2:0] T_OR  = 3'd3;
  localparam logic [2:0] T_XOR = 3'd4;
  localparam logic [2:0] T_MUL = 3'd5;
  localparam logic [2:0] T_SHL = 3'd6;
  localparam logic [2:0] T_SHR = 3'd7;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [1:0]   dr = '0;
  logic [W-1:0] s = '0;
  logic [W-1:0] d = '0;
  logic         busy, done, we, cf, zf;
  logic [W-1:0] i;
  logic [1:0]   dr_out;
  alu_exec_pkg::state_e dbg_state;

  alu_exec #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .dr          (dr),
    .s           (s),
    .d           (d),
    .busy        (busy),
    .done        (done),
    .we          (we),
    .i           (i),
    .dr_out      (dr_out),
    .cf          (cf),
    .zf          (zf),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [W-1:0] i;
    logic         cf;
    logic         zf;
    logic [1:0]   dr;
    int           cyc;   // latency from the model, then absolute done cycle
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_done = 0;
  int   run_lo = 0;
  int   run_hi = 0;

  logic [W-1:0] hold_i  = '0;
  logic         hold_cf = 1'b0;
  logic         hold_zf = 1'b0;
  logic [1:0]   hold_dr = '0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] dv,
                                 input logic [W-1:0] sv, input logic [1:0] drv);
    exp_t        e;
    int unsigned a, b, r, n, m;
    bit          c;
    a = dv; b = sv; m = 1 << W; r = 0; c = 0; n = b % 8;
    e.cyc = 0;
    case (o)
      T_ADD: begin r = (a + b) % m; c = (a + b) >= m; end
      T_SUB: begin r = (a + m - b) % m; c = a < b; end
      T_AND: r = a & b;
      T_OR:  r = a | b;
      T_XOR: r = a ^ b;
      T_MUL: begin r = (a * b) % m; c = ((a * b) / m) != 0; e.cyc = W; end
      T_SHL: begin
        r = (a << n) % m;
        c = (n == 0) ? 1'b0 : bit'((a >> (W - n)) & 1);
        e.cyc = n;
      end
      default: begin
        r = a >> n;
        c = (n == 0) ? 1'b0 : bit'((a >> (n - 1)) & 1);
        e.cyc = n;
      end
    endcase
    e.i  = r[W-1:0];
    e.cf = c;
    e.zf = (r == 0);
    e.dr = drv;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  // Called on a falling edge; waits until the model says the block accepts.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] dv,
                       input logic [W-1:0] sv, input logic [1:0] drv);
    exp_t e;
    while (cyc < last_done) @(negedge clk);
    e = model(o, dv, sv, drv);
    e.cyc = cyc + 1 + e.cyc;
    run_lo = cyc + 1;
    run_hi = e.cyc;
    last_done = e.cyc;
    exp_q.push_back(e);
    start = 1'b1; op = o; d = dv; s = sv; dr = drv;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); d = W'($urandom); s = W'($urandom); dr = 2'($urandom);
  endtask

  // A start pulse while the block is iterating; it must have no effect.
  task automatic poke_ignored();
    start = 1'b1;
    op = 3'($urandom); d = W'($urandom); s = W'($urandom); dr = 2'($urandom);
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    bit   exp_done;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_we", 16'(we), 16'd0);
        check("rst_i", 16'(i), 16'd0);
        check("rst_cf", 16'(cf), 16'd0);
        check("rst_zf", 16'(zf), 16'd0);
        check("rst_dr_out", 16'(dr_out), 16'd0);
        exp_q.delete();
        hold_i = '0; hold_cf = 1'b0; hold_zf = 1'b0; hold_dr = '0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_done: expected done at cycle %0d, no done pulse by cycle %0d",
                   exp_q[0].cyc, cyc);
          void'(exp_q.pop_front());
        end
        exp_done = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check("done", 16'(done), 16'(exp_done));
        check("we", 16'(we), 16'(exp_done));
        if (exp_done) begin
          e = exp_q.pop_front();
          hold_i = e.i; hold_cf = e.cf; hold_zf = e.zf; hold_dr = e.dr;
        end
        check("i", 16'(i), 16'(hold_i));
        check("cf", 16'(cf), 16'(hold_cf));
        check("zf", 16'(zf), 16'(hold_zf));
        check("dr_out", 16'(dr_out), 16'(hold_dr));
        check("busy", 16'(busy), 16'((cyc >= run_lo) && (cyc < run_hi)));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rd, rs;
    logic [1:0]   rdr;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Documented vectors.
    issue(T_ADD, 8'hF0, 8'h20, 2'd2);
    issue(T_SUB, 8'h05, 8'h05, 2'd1);
    issue(T_SUB, 8'h03, 8'h05, 2'd3);
    issue(T_MUL, 8'h0D, 8'h0B, 2'd0);
    issue(T_MUL, 8'h10, 8'h10, 2'd1);
    issue(T_SHL, 8'h81, 8'h03, 2'd2);
    issue(T_SHR, 8'h81, 8'h01, 2'd3);
    issue(T_SHL, 8'h5A, 8'h00, 2'd1);
    issue(T_AND, 8'hCC, 8'hAA, 2'd0);
    issue(T_OR,  8'hCC, 8'hAA, 2'd1);
    issue(T_XOR, 8'hCC, 8'hCC, 2'd2);
    repeat (2) @(negedge clk);

    // Start pulses during a multiply are ignored.
    issue(T_MUL, 8'h37, 8'hC5, 2'd3);
    poke_ignored();
    @(negedge clk);
    poke_ignored();

    // Back-to-back: new ops accepted in the DONE cycle.
    issue(T_ADD, 8'h11, 8'h22, 2'd0);
    issue(T_SUB, 8'h22, 8'h11, 2'd1);
    issue(T_SHR, 8'hF0, 8'h04, 2'd2);
    issue(T_XOR, 8'h0F, 8'hF0, 2'd3);
    repeat (2) @(negedge clk);

    // Reset in the middle of a multiply aborts it.
    issue(T_MUL, 8'hFF, 8'hFF, 2'd2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_done = cyc + 1;
    run_hi = cyc + 1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // Reset and start together: the start is discarded.
    rst = 1'b1; start = 1'b1; op = T_ADD; d = 8'h01; s = 8'h01; dr = 2'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    issue(T_ADD, 8'hFF, 8'h01, 2'd3);

    // Randomized operations with random gaps and ignored pokes.
    for (int n = 0; n < 200; n++) begin
      ro  = 3'($urandom_range(0, 7));
      rd  = W'($urandom);
      rs  = W'($urandom);
      rdr = 2'($urandom);
      if ($urandom_range(0, 7) == 0) rs = '0;
      issue(ro, rd, rs, rdr);
      if ((cyc < last_done) && (cyc >= run_lo) && ($urandom_range(0, 3) == 0))
        poke_ignored();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drain outstanding results within a bounded number of cycles.
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 8, data width of operands and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only when block is accepting (REQ-012).
REQ-005 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 SHL, 111 SHR.
REQ-006 dr  input  2  destination register index, captured with start.
REQ-007 s  input  WIDTH  source operand (register-file source port).
REQ-008 d  input  WIDTH  destination operand (register-file destination port).
REQ-009 busy  output  1  high while an operation is iterating.
REQ-010 done, we  output  1 each  one-cycle pulse marking result valid; we drives the register-file write enable.
REQ-011 i  output  WIDTH; dr_out  output  2; cf, zf  output  1 each: write-back data, write index, carry and zero flags.

Function
REQ-012 States IDLE, RUN, DONE; start accepted in IDLE or DONE, ignored in RUN.
REQ-013 On acceptance in cycle T: s, d, op, dr latched; later input changes have no effect.
REQ-014 Result is d op s (two-address form, d is left operand).
REQ-015 ADD/SUB/AND/OR/XOR: no RUN; DONE in T+1.
REQ-016 ADD cf = carry out; SUB cf = borrow (d < s unsigned); logic ops cf = 0.
REQ-017 MUL: shift-add, one multiplier bit per cycle, WIDTH cycles in RUN; DONE in T+1+WIDTH; i = low WIDTH bits of product; cf = 1 iff high WIDTH bits nonzero.
REQ-018 SHL/SHR: shift d by n = s[2:0], one bit per RUN cycle, zero fill; DONE in T+1+n; n = 0 goes straight to DONE at T+1 with i = d, cf = 0.
REQ-019 Shift cf = last bit shifted out.
REQ-020 zf = 1 iff i == 0, evaluated on the final result.
REQ-021 done and we high exactly in the DONE cycle; busy high exactly in RUN cycles.
REQ-022 i, dr_out, cf, zf update only on entering DONE and hold until the next DONE.
REQ-023 start accepted in DONE starts the next op back-to-back (DONE -> RUN, or DONE -> DONE for single-cycle ops); otherwise DONE -> IDLE.
REQ-024 i and dr_out stable across the full DONE cycle, including the falling edge used by the register-file write.

Reset
REQ-025 rst in any state: next state IDLE; busy, done, we, cf, zf, i, dr_out all 0.
REQ-026 rst during RUN aborts the op; no done/we pulse follows.
REQ-027 rst and start in the same cycle: rst wins, start discarded.

Structure
REQ-028 Package alu_exec_pkg holds the opcode constants, state encoding and WIDTH default.
REQ-029 Single-cycle ADD/SUB/AND/OR/XOR logic in one combinational sub-module alu_comb (inputs a, b, op; outputs y, c).
REQ-030 Iteration counter sized for WIDTH; MUL accumulator 2*WIDTH bits.

Verification
REQ-031 ADD d=0xF0, s=0x20, dr=2 -> T+1: done=we=1, i=0x10, cf=1, zf=0, dr_out=2.
REQ-032 SUB d=0x05, s=0x05 -> T+1: i=0x00, zf=1, cf=0; then SUB d=0x03, s=0x05 -> i=0xFE, cf=1.
REQ-033 MUL d=0x0D, s=0x0B -> busy T+1..T+8, done at T+9, i=0x8F, cf=0; MUL d=0x10, s=0x10 -> i=0x00, cf=1, zf=1.
REQ-034 SHL d=0x81, s=0x03 -> done at T+4, i=0x08, cf=0; SHR d=0x81, s=0x01 -> done at T+2, i=0x40, cf=1; SHL s=0x00 -> T+1, i=d.
REQ-035 start pulsed during MUL RUN -> ignored, single done; start held in DONE cycle -> back-to-back ADD done one cycle later.
REQ-036 rst asserted at T+4 of MUL -> no done/we ever; all outputs 0; next start runs normally.
